instruction_sequencer: RTL and testbench

Fetch/execute sequencer for the core. It owns the program counter and drives memory fetch handshakes. It presents the fetched word, plus an `isNOP` qualifier, to the combinational instruction decoder, and advances, redirects or traps based on the decoder's `invalidInstruction` flag and the execute stage's completion. It sits between the instruction memory port and the decode/execute logic, one instruction in flight at a time.

---
 rtl/instruction_sequencer.sv | 150 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/execute sequencer owning the PC.
// One instruction in flight; drives fetch handshake and trap entry.
module instruction_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        fetchRequest,
  output logic [31:0] fetchAddress,
  input  logic        fetchAck,
  input  logic [31:0] fetchData,
  input  logic        fetchError,
  output logic [31:0] currentInstruction,
  output logic        isNOP,
  input  logic        invalidInstruction,
  input  logic        executeDone,
  input  logic        jumpEnable,
  input  logic [31:0] jumpAddress,
  input  logic [31:0] trapVector,
  output logic [31:0] programCounter,
  output logic        trapTaken,
  output logic [1:0]  trapCause,
  output logic [31:0] trapPC
);

  typedef enum logic [1:0] {
    S_HALT,
    S_FETCH,
    S_EXEC,
    S_TRAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_tpc;
  logic [1:0]  r_cause;
  logic [1:0]  w_cause;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        w_enter;
  logic        w_latch;
  logic        w_to;
  logic [31:0] w_ret_pc;

  assign w_ret_pc = jumpEnable ? jumpAddress
                               : r_pc + 32'd4;

  // ack is tested before this, so ack wins a same-cycle timeout
  assign w_to = (FETCH_TIMEOUT != 8'd0) &&
                (r_cnt == FETCH_TIMEOUT - 8'd1);

  always_comb begin
    w_next    = r_state;
    w_pc_nxt  = r_pc;
    w_cnt_nxt = r_cnt;
    w_cause   = r_cause;
    w_enter   = 1'b0;
    w_latch   = 1'b0;
    case (r_state)
      S_HALT: begin
        if (enable) begin
          if (r_pc[1:0] != 2'd0) begin
            w_next  = S_TRAP;
            w_cause = 2'd0;
            w_enter = 1'b1;
          end else begin
            w_next = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (fetchAck) begin
          w_cnt_nxt = 8'd0;
          if (fetchError) begin
            w_next  = S_TRAP;
            w_cause = 2'd1;
            w_enter = 1'b1;
          end else begin
            w_next  = S_EXEC;
            w_latch = 1'b1;
          end
        end else if (w_to) begin
          w_cnt_nxt = 8'd0;
          w_next    = S_TRAP;
          w_cause   = 2'd1;
          w_enter   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (invalidInstruction) begin
          w_next  = S_TRAP;
          w_cause = 2'd2;
          w_enter = 1'b1;
        end else if (executeDone) begin
          w_pc_nxt = w_ret_pc;
          if (!enable || w_ret_pc[1:0] != 2'd0)
            w_next = S_HALT;
          else
            w_next = S_FETCH;
        end
      end
      S_TRAP: begin
        w_pc_nxt = trapVector;
        w_next   = S_HALT;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  // trap cause/PC captured on entry so they are valid with the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HALT;
      r_pc    <= RESET_VECTOR;
      r_instr <= 32'd0;
      r_tpc   <= 32'd0;
      r_cause <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch)
        r_instr <= fetchData;
      if (w_enter) begin
        r_tpc   <= r_pc;
        r_cause <= w_cause;
      end
    end
  end

  assign fetchRequest       = (r_state == S_FETCH);
  assign fetchAddress       = r_pc;
  assign currentInstruction = r_instr;
  assign isNOP              = (r_state != S_EXEC);
  assign programCounter     = r_pc;
  assign trapTaken          = (r_state == S_TRAP);
  assign trapCause          = r_cause;
  assign trapPC             = r_tpc;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed stimulus, scoreboard monitor.
// Events: fetch start, execute entry, trap pulse.
module tb_instruction_sequencer;

  localparam logic [31:0] TVEC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchAck;
  logic [31:0] fetchData;
  logic        fetchError;
  logic [31:0] currentInstruction;
  logic        isNOP;
  logic        invalidInstruction;
  logic        executeDone;
  logic        jumpEnable;
  logic [31:0] jumpAddress;
  logic [31:0] trapVector;
  logic [31:0] programCounter;
  logic        trapTaken;
  logic [1:0]  trapCause;
  logic [31:0] trapPC;

  instruction_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .FETCH_TIMEOUT(8'd4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .fetchRequest      (fetchRequest),
    .fetchAddress      (fetchAddress),
    .fetchAck          (fetchAck),
    .fetchData         (fetchData),
    .fetchError        (fetchError),
    .currentInstruction(currentInstruction),
    .isNOP             (isNOP),
    .invalidInstruction(invalidInstruction),
    .executeDone       (executeDone),
    .jumpEnable        (jumpEnable),
    .jumpAddress       (jumpAddress),
    .trapVector        (trapVector),
    .programCounter    (programCounter),
    .trapTaken         (trapTaken),
    .trapCause         (trapCause),
    .trapPC            (trapPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] v;
    logic [1:0]  c;
  } ev_t;

  ev_t q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endfunction

  function automatic void bound_fail(string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endfunction

  function automatic void exp_f(logic [31:0] a);
    ev_t e;
    e.kind = 0; e.v = a; e.c = 2'd0;
    q.push_back(e);
  endfunction

  function automatic void exp_e(logic [31:0] i);
    ev_t e;
    e.kind = 1; e.v = i; e.c = 2'd0;
    q.push_back(e);
  endfunction

  function automatic void exp_t(logic [1:0] c,
                                logic [31:0] pc);
    ev_t e;
    e.kind = 2; e.v = pc; e.c = c;
    q.push_back(e);
  endfunction

  function automatic void pop(int kind,
                              logic [31:0] v,
                              logic [1:0] c);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%0d required=none",
               kind);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      case (e.kind)
        0: chk("fetch_addr", v, e.v);
        1: chk("exec_instr", v, e.v);
        default: begin
          chk("trap_cause", 32'(c), 32'(e.c));
          chk("trap_pc", v, e.v);
        end
      endcase
    end
  endfunction

  logic prev_req = 1'b0;
  logic prev_nop = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fetchRequest && !prev_req)
        pop(0, fetchAddress, 2'd0);
      if (!isNOP && prev_nop)
        pop(1, currentInstruction, 2'd0);
      if (trapTaken)
        pop(2, trapPC, trapCause);
    end
    prev_req <= fetchRequest;
    prev_nop <= isNOP;
  end

  task automatic wait_req();
    int n = 0;
    while (!fetchRequest && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!fetchRequest)
      bound_fail("wait_fetch_request");
  endtask

  task automatic serve(input logic [31:0] d,
                       input logic err,
                       input int lat);
    wait_req();
    repeat (lat) @(negedge clk);
    fetchData  = d;
    fetchError = err;
    fetchAck   = 1'b1;
    @(negedge clk);
    fetchAck   = 1'b0;
    fetchError = 1'b0;
  endtask

  task automatic exec(input logic inval,
                      input logic jmp,
                      input logic [31:0] ja);
    invalidInstruction = inval;
    executeDone        = 1'b1;
    jumpEnable         = jmp;
    jumpAddress        = ja;
    @(negedge clk);
    invalidInstruction = 1'b0;
    executeDone        = 1'b0;
    jumpEnable         = 1'b0;
    jumpAddress        = 32'd0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_req"}, 32'(fetchRequest), 32'd0);
    chk({tag, "_nop"}, 32'(isNOP), 32'd1);
    chk({tag, "_pc"}, programCounter, 32'd0);
    chk({tag, "_instr"}, currentInstruction, 32'd0);
    chk({tag, "_ttaken"}, 32'(trapTaken), 32'd0);
    chk({tag, "_tcause"}, 32'(trapCause), 32'd0);
    chk({tag, "_tpc"}, trapPC, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst_n              = 1'b0;
    enable             = 1'b0;
    fetchAck           = 1'b0;
    fetchData          = 32'd0;
    fetchError         = 1'b0;
    invalidInstruction = 1'b0;
    executeDone        = 1'b0;
    jumpEnable         = 1'b0;
    jumpAddress        = 32'd0;
    trapVector         = TVEC;
    #1;
    chk_reset("por");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("halt_idle_req", 32'(fetchRequest), 32'd0);

    // straight-line 0x0 -> 0x4 -> 0x8
    exp_f(32'h0); exp_e(32'h0000_0013); exp_f(32'h4);
    enable = 1'b1;
    serve(32'h0000_0013, 1'b0, 1);
    exec(1'b0, 1'b0, 32'd0);
    exp_e(32'h0040_0093); exp_f(32'h8);
    serve(32'h0040_0093, 1'b0, 0);
    exec(1'b0, 1'b0, 32'd0);

    // illegal plus done at 0x8: trap wins, no PC+4
    exp_e(32'hFFFF_FFFF); exp_t(2'd2, 32'h8); exp_f(TVEC);
    serve(32'hFFFF_FFFF, 1'b0, 0);
    exec(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("pc_after_illegal", programCounter, TVEC);

    // aligned jump, then misaligned jump
    exp_e(32'h1000_006F); exp_f(32'h100);
    serve(32'h1000_006F, 1'b0, 0);
    exec(1'b0, 1'b1, 32'h100);
    exp_e(32'h0020_006F); exp_t(2'd0, 32'h102); exp_f(TVEC);
    serve(32'h0020_006F, 1'b0, 0);
    exec(1'b0, 1'b1, 32'h102);

    // bus error on fetch
    exp_t(2'd1, TVEC); exp_f(TVEC);
    serve(32'hDEAD_BEEF, 1'b1, 0);

    // timeout of 4 request cycles
    exp_t(2'd1, TVEC); exp_f(TVEC);
    wait_req();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trapTaken) break;
      if (fetchRequest) n++;
    end
    if (!trapTaken) bound_fail("timeout_trap");
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_req_drop", 32'(fetchRequest), 32'd0);

    // PC wrap at 0xFFFF_FFFC
    exp_e(32'h0000_0033); exp_f(32'hFFFF_FFFC);
    serve(32'h0000_0033, 1'b0, 0);
    exec(1'b0, 1'b1, 32'hFFFF_FFFC);
    exp_e(32'h0000_0073); exp_f(32'h0);
    serve(32'h0000_0073, 1'b0, 0);
    exec(1'b0, 1'b0, 32'd0);

    // enable drops mid-fetch: fetch and retire still complete
    enable = 1'b0;
    exp_e(32'h1234_5678);
    serve(32'h1234_5678, 1'b0, 2);
    exec(1'b0, 1'b0, 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (fetchRequest) seen++;
    end
    chk("halt_no_req", 32'(seen), 32'd0);
    chk("halt_pc", programCounter, 32'h4);
    chk("halt_nop", 32'(isNOP), 32'd1);

    // async reset during EXECUTE
    exp_f(32'h4); exp_e(32'hCAFE_0001);
    enable = 1'b1;
    serve(32'hCAFE_0001, 1'b0, 0);
    chk("exec_nop_low", 32'(isNOP), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
